// File: rtl/qdec_pkg.sv
// Shared phase encoding and mode constants for the quadrature step decoder.
// Optional stability filter is enabled by defining QDEC_FILTER_EN.
package qdec_pkg;

    // Encodings equal the raw {A, B} sample so a sample casts straight to phase_t.
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } phase_t;

    localparam int MODE_X1 = 1;
    localparam int MODE_X2 = 2;
    localparam int MODE_X4 = 4;

    function automatic phase_t next_up(input phase_t p);
        phase_t n;
        n = PH_01;
        case (p)
            PH_00: n = PH_01;
            PH_01: n = PH_11;
            PH_11: n = PH_10;
            PH_10: n = PH_00;
            default: n = PH_01;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// Two-flop synchronizer for one encoder phase; with QDEC_FILTER_EN a stability filter
// follows it. Latency 2 clk, plus FILTER_LEN clk when filtered.
module qdec_sync_filter
`ifdef QDEC_FILTER_EN
#(
    parameter int FILTER_LEN = 3
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_ph
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

`ifdef QDEC_FILTER_EN
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          r_filt;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive samples disagreeing with r_filt; the last one flips it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (r_sync == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_filt <= r_sync;
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_ph = r_filt;
`else
    assign o_ph = r_sync;
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder producing one-clk step strobes with direction and an error counter.
// Latency 3 clk from input sample to enable (3+FILTER_LEN with QDEC_FILTER_EN defined).
module quad_step_decoder
    import qdec_pkg::*;
#(
    parameter int MODE       = 4,
    parameter int ERR_W      = 8,
    parameter int FILTER_LEN = 3
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    output logic             enable,
    output logic             up_down,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    // An unsupported configuration never emits steps.
    localparam bit CFG_OK = ((MODE == MODE_X1) || (MODE == MODE_X2) || (MODE == MODE_X4))
                            && (FILTER_LEN >= 1);

    logic             w_a;
    logic             w_b;
    phase_t           w_cur;
    logic [1:0]       w_diff;
    logic             w_legal;
    logic             w_illegal;
    logic             w_up;
    logic             w_qual;

    phase_t           r_prev;
    logic [1:0]       r_prime;
    logic             r_enable;
    logic             r_up_down;
    logic             r_err;
    logic [ERR_W-1:0] r_err_cnt;

`ifdef QDEC_FILTER_EN
    qdec_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_a (
        .clk(clk), .reset(reset), .i_async(a_in), .o_ph(w_a)
    );
    qdec_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_b (
        .clk(clk), .reset(reset), .i_async(b_in), .o_ph(w_b)
    );
`else
    qdec_sync_filter u_sync_a (
        .clk(clk), .reset(reset), .i_async(a_in), .o_ph(w_a)
    );
    qdec_sync_filter u_sync_b (
        .clk(clk), .reset(reset), .i_async(b_in), .o_ph(w_b)
    );
`endif

    always_comb begin
        w_cur     = phase_t'({w_a, w_b});
        w_diff    = w_cur ^ r_prev;
        w_legal   = ^w_diff;
        w_illegal = &w_diff;
        w_up      = (w_cur == next_up(r_prev));
        // Entry into 00 qualifies in every legal mode; X2 adds 11, X4 takes everything.
        w_qual    = CFG_OK && ((MODE == MODE_X4)
                               || ((MODE == MODE_X2) && (w_cur == PH_11))
                               || (w_cur == PH_00));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev    <= PH_00;
            r_prime   <= 2'd3;
            r_enable  <= 1'b0;
            r_up_down <= 1'b1;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_enable <= 1'b0;
            r_err    <= 1'b0;
            // prev follows cur in every case: idle, silent step, step and resync after a jump.
            r_prev   <= w_cur;
            if (r_prime != 2'd0) begin
                r_prime <= r_prime - 2'd1;
            end else if (w_illegal) begin
                r_err <= 1'b1;
                if (r_err_cnt != {ERR_W{1'b1}}) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end else if (w_legal && w_qual) begin
                r_enable  <= 1'b1;
                r_up_down <= w_up;
            end
        end
    end

    assign enable  = r_enable;
    assign up_down = r_up_down;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: an X4/ERR_W=8 and an X1/ERR_W=2 instance share inputs.
// Covers QDEC_FILTER_EN builds as well (glitch rejection and filtered latency).
module tb_quad_step_decoder;

    localparam int FL = 3;
`ifdef QDEC_FILTER_EN
    localparam int LAT = 3 + FL;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_in = 1'b0;
    logic       b_in = 1'b0;
    logic       en0, ud0, err0;
    logic [7:0] cnt0;
    logic       en1, ud1, err1;
    logic [1:0] cnt1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    quad_step_decoder #(.MODE(4), .ERR_W(8), .FILTER_LEN(FL)) u_dut0 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
        .enable(en0), .up_down(ud0), .err(err0), .err_cnt(cnt0)
    );

    quad_step_decoder #(.MODE(1), .ERR_W(2), .FILTER_LEN(FL)) u_dut1 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
        .enable(en1), .up_down(ud1), .err(err1), .err_cnt(cnt1)
    );

    typedef struct {
        bit is_err;
        bit ud;
        int cnt;
        int at;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    ev_t m0, m1;
    int  checks = 0;
    int  failures = 0;
    int  t_chg = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int dut, input bit is_err, input bit ud, input int cnt);
        ev_t e;
        e = '{is_err: is_err, ud: ud, cnt: cnt, at: t_chg + LAT};
        if (dut == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic move(input logic [1:0] ab);
        @(posedge clk);
        #1;
        {a_in, b_in} = ab;
        t_chg = cyc;
    endtask

    task automatic hold();
        repeat (HOLD - 1) @(posedge clk);
    endtask

    task automatic check_reset_vals();
        chk("rst_enable0", en0, 0);
        chk("rst_up_down0", ud0, 1);
        chk("rst_err0", err0, 0);
        chk("rst_err_cnt0", cnt0, 0);
        chk("rst_enable1", en1, 0);
        chk("rst_up_down1", ud1, 1);
        chk("rst_err1", err1, 0);
        chk("rst_err_cnt1", cnt1, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && (en0 || err0)) begin
            if (q0.size() == 0) begin
                chk("d0_unexpected_event", {30'd0, en0, err0}, 0);
            end else begin
                m0 = q0.pop_front();
                chk("d0_err", err0, m0.is_err);
                chk("d0_enable", en0, !m0.is_err);
                chk("d0_up_down", ud0, m0.ud);
                chk("d0_err_cnt", cnt0, m0.cnt);
                chk("d0_cycle", cyc, m0.at);
            end
        end
        if (!reset && (en1 || err1)) begin
            if (q1.size() == 0) begin
                chk("d1_unexpected_event", {30'd0, en1, err1}, 0);
            end else begin
                m1 = q1.pop_front();
                chk("d1_err", err1, m1.is_err);
                chk("d1_enable", en1, !m1.is_err);
                chk("d1_up_down", ud1, m1.ud);
                chk("d1_err_cnt", cnt1, m1.cnt);
                chk("d1_cycle", cyc, m1.at);
            end
        end
    end

    initial begin
        reset = 1'b1;
        {a_in, b_in} = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        reset = 1'b0;
        hold();

        // X4 up sequence; the X1 instance steps only on entry into 00
        move(2'b01); push(0, 0, 1, 0); hold();
        move(2'b11); push(0, 0, 1, 0); hold();
        move(2'b10); push(0, 0, 1, 0); hold();
        move(2'b00); push(0, 0, 1, 0); push(1, 0, 1, 0); hold();

        // Reverse sequence
        move(2'b10); push(0, 0, 0, 0); hold();
        move(2'b11); push(0, 0, 0, 0); hold();
        move(2'b01); push(0, 0, 0, 0); hold();
        move(2'b00); push(0, 0, 0, 0); push(1, 0, 0, 0); hold();

        // Illegal jump 00->11, then a normal up step 11->10
        move(2'b11); push(0, 1, 0, 1); push(1, 1, 0, 1); hold();
        move(2'b10); push(0, 0, 1, 1); hold();
        @(negedge clk);
        chk("d1_up_down_held", ud1, 0);

        // Reset mid-operation with the inputs away from 00, then prime
        @(posedge clk);
        #1;
        reset = 1'b1;
`ifdef QDEC_FILTER_EN
        {a_in, b_in} = 2'b00;
`else
        {a_in, b_in} = 2'b01;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        reset = 1'b0;
        hold();
`ifdef QDEC_FILTER_EN
        move(2'b01); push(0, 0, 1, 0); hold();
`endif
        move(2'b11); push(0, 0, 1, 0); hold();

        // Five illegal jumps: 2-bit counter saturates at 3
        move(2'b00); push(0, 1, 1, 1); push(1, 1, 1, 1); hold();
        move(2'b11); push(0, 1, 1, 2); push(1, 1, 1, 2); hold();
        move(2'b00); push(0, 1, 1, 3); push(1, 1, 1, 3); hold();
        move(2'b11); push(0, 1, 1, 4); push(1, 1, 1, 3); hold();
        move(2'b00); push(0, 1, 1, 5); push(1, 1, 1, 3); hold();
        move(2'b01); push(0, 0, 1, 5); hold();

`ifdef QDEC_FILTER_EN
        // 2-clk glitch on A is rejected; a long change steps at the filtered latency
        move(2'b11);
        repeat (2) @(posedge clk);
        #1;
        {a_in, b_in} = 2'b01;
        hold();
        move(2'b11); push(0, 0, 1, 5); hold();
`endif

        repeat (HOLD) @(posedge clk);
        chk("d0_missing_events", q0.size(), 0);
        chk("d1_missing_events", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
